reg_mem_wb_pipe: RTL and testbench

Parametrised MEM->WB pipeline boundary register for the multi-issue core. It carries LANES independent register-file write requests, with a valid/ready handshake on both sides. A 2-entry skid buffer lets WB apply backpressure without a combinational ready path into MEM. It adds flush support and optional suppression of writes to register x0.

---
 rtl/reg_mem_wb_pipe.sv | 124 ++++++++++++
 tb/tb_reg_mem_wb_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_wb_pipe.sv
// MEM->WB boundary register: LANES write requests behind a head + skid register pair,
// so WB backpressure never reaches MEM through a combinational ready path.
module reg_mem_wb_pipe #(
  parameter int LANES         = 1,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 32,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_we,
  input  logic [LANES*ADDR_W-1:0] in_waddr,
  input  logic [LANES*DATA_W-1:0] in_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_we,
  output logic [LANES*ADDR_W-1:0] out_waddr,
  output logic [LANES*DATA_W-1:0] out_wdata
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e                    occ_q, occ_d;
  logic                    in_ready_q, in_ready_d;
  logic [LANES-1:0]        head_we_q, head_we_d, skid_we_q, skid_we_d;
  logic [LANES*ADDR_W-1:0] head_addr_q, head_addr_d, skid_addr_q, skid_addr_d;
  logic [LANES*DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [LANES-1:0]        cap_we;
  logic                    accept, pop;

  // Writes to x0 are dropped at capture so WB never has to look at the address.
  function automatic logic [LANES-1:0] capture_we(input logic [LANES-1:0]        we,
                                                  input logic [LANES*ADDR_W-1:0] addr);
    logic [LANES-1:0] res;
    for (int i = 0; i < LANES; i++) begin
      res[i] = we[i] & ~(ZERO_SUPPRESS && (addr[i*ADDR_W +: ADDR_W] == '0));
    end
    return res;
  endfunction

  assign cap_we = capture_we(in_we, in_waddr);
  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    head_we_d   = head_we_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_we_d   = skid_we_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      occ_d = EMPTY;
    end else begin
      unique case (occ_q)
        EMPTY: begin
          if (accept) begin
            occ_d       = ONE;
            head_we_d   = cap_we;
            head_addr_d = in_waddr;
            head_data_d = in_wdata;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_we_d   = cap_we;
            head_addr_d = in_waddr;
            head_data_d = in_wdata;
          end else if (accept) begin
            occ_d       = FULL;
            skid_we_d   = cap_we;
            skid_addr_d = in_waddr;
            skid_data_d = in_wdata;
          end else if (pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            occ_d       = ONE;
            head_we_d   = skid_we_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
    in_ready_d = (occ_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= EMPTY;
      in_ready_q  <= 1'b1;
      head_we_q   <= '0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_we_q   <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      head_we_q   <= head_we_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_we_q   <= skid_we_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != EMPTY);
  assign out_we    = head_we_q & {LANES{out_valid}};
  assign out_waddr = head_addr_q;
  assign out_wdata = head_data_q;

endmodule

// File: tb/tb_reg_mem_wb_pipe.sv
// Bench for reg_mem_wb_pipe: two 2-lane instances (x0 suppression on/off) share stimulus
// and are checked every cycle against a queue model of the two-entry buffer.
module tb_reg_mem_wb_pipe;
  localparam int LANES = 2, ADDR_W = 5, DATA_W = 32;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [LANES-1:0]        in_we = '0;
  logic [LANES*ADDR_W-1:0] in_waddr = '0;
  logic [LANES*DATA_W-1:0] in_wdata = '0;

  logic                    rdy_z, vld_z, rdy_n, vld_n;
  logic [LANES-1:0]        we_z, we_n;
  logic [LANES*ADDR_W-1:0] addr_z, addr_n;
  logic [LANES*DATA_W-1:0] data_z, data_n;

  reg_mem_wb_pipe #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_SUPPRESS(1'b1)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_z),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .out_valid(vld_z),
    .out_ready(out_ready), .out_we(we_z), .out_waddr(addr_z), .out_wdata(data_z));

  reg_mem_wb_pipe #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_SUPPRESS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
    .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .out_valid(vld_n),
    .out_ready(out_ready), .out_we(we_n), .out_waddr(addr_n), .out_wdata(data_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]        we;
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES*DATA_W-1:0] data;
  } bundle_t;

  bundle_t q[$];
  logic                    exp_ready = 1'b1;
  logic [LANES*ADDR_W-1:0] last_addr = '0;
  logic [LANES*DATA_W-1:0] last_data = '0;
  int n_total = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [LANES-1:0] zs_we(input bundle_t b);
    logic [LANES-1:0] r;
    r = b.we;
    if (b.addr[4:0] == 5'd0) r[0] = 1'b0;
    if (b.addr[9:5] == 5'd0) r[1] = 1'b0;
    return r;
  endfunction

  // Reference model: a FIFO of at most two bundles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_ready = 1'b1;
      last_addr = '0;
      last_data = '0;
    end else begin
      bit acc, pp;
      acc = in_valid && exp_ready;
      pp  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back('{we: in_we, addr: in_waddr, data: in_wdata});
      end
      exp_ready = (q.size() != 2);
      if (q.size() > 0) begin
        last_addr = q[0].addr;
        last_data = q[0].data;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid_z", {63'd0, vld_z}, {63'd0, q.size() != 0});
    chk("out_valid_n", {63'd0, vld_n}, {63'd0, q.size() != 0});
    chk("in_ready_z", {63'd0, rdy_z}, {63'd0, exp_ready});
    chk("in_ready_n", {63'd0, rdy_n}, {63'd0, exp_ready});
    if (q.size() != 0) begin
      chk("out_we_z", {62'd0, we_z}, {62'd0, zs_we(q[0])});
      chk("out_we_n", {62'd0, we_n}, {62'd0, q[0].we});
      chk("out_waddr", {54'd0, addr_z}, {54'd0, q[0].addr});
      chk("out_wdata", data_n, q[0].data);
    end else begin
      chk("idle_we", {60'd0, we_z, we_n}, 64'd0);
      chk("idle_waddr", {54'd0, addr_z}, {54'd0, last_addr});
      chk("idle_wdata", data_z, last_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    in_valid = v;
    in_we    = we;
    in_waddr = {a1, a0};
    in_wdata = {d1, d0};
  endtask

  initial begin
    // Reset held with a bundle offered
    drive(1'b1, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2);
    repeat (3) cyc();
    chk("rst_valid", {63'd0, vld_z}, 64'd0);
    chk("rst_we", {62'd0, we_z}, 64'd0);
    chk("rst_ready", {63'd0, rdy_z}, 64'd1);
    rst = 1'b1;
    drive(1'b1, 2'b01, 5'd5, 5'd3, 32'hDEADBEEF, 32'h0);
    cyc();
    chk("first_valid", {63'd0, vld_z}, 64'd1);
    chk("first_addr", {59'd0, addr_z[4:0]}, 64'd5);
    chk("first_data", {32'd0, data_z[31:0]}, 64'hDEADBEEF);

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b11, 5'd1, 5'd2, i, i + 100);
      cyc();
      chk("stream_data", {32'd0, data_z[31:0]}, i);
      chk("stream_ready", {63'd0, rdy_z}, 64'd1);
    end
    in_valid = 1'b0;
    repeat (2) cyc();

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'hA, 32'hA);
    cyc();
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'hB, 32'hB);
    cyc();
    chk("bp_ready_low", {63'd0, rdy_z}, 64'd0);
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'hC, 32'hC);
    repeat (2) cyc();
    chk("bp_hold_A", {32'd0, data_z[31:0]}, 64'hA);
    out_ready = 1'b1;
    cyc();
    chk("bp_head_B", {32'd0, data_z[31:0]}, 64'hB);
    chk("bp_ready_up", {63'd0, rdy_z}, 64'd1);
    cyc();
    chk("bp_head_C", {32'd0, data_z[31:0]}, 64'hC);
    in_valid = 1'b0;
    cyc();
    chk("bp_drained", {63'd0, vld_z}, 64'd0);

    // x0 suppression
    drive(1'b1, 2'b11, 5'd0, 5'd7, 32'h11, 32'h22);
    cyc();
    chk("x0_we_zs1", {62'd0, we_z}, 64'd2);
    chk("x0_we_zs0", {62'd0, we_n}, 64'd3);
    in_valid = 1'b0;
    cyc();

    // Flush from FULL with a bundle offered
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h51, 32'h52);
    cyc();
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h61, 32'h62);
    cyc();
    flush = 1'b1;
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h71, 32'h72);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {63'd0, vld_z}, 64'd0);
    chk("flush_we", {62'd0, we_z}, 64'd0);
    chk("flush_ready", {63'd0, rdy_z}, 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_no_stale", {63'd0, vld_z}, 64'd0);

    // Async reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h81, 32'h82);
    cyc();
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'h91, 32'h92);
    cyc();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, vld_z}, 64'd0);
    chk("arst_data", data_z, 64'd0);
    chk("arst_ready", {63'd0, rdy_z}, 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("arst_ready_rel", {63'd0, rdy_z}, 64'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), a0, a1, $urandom, $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 500) == 0) begin
        #2 rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
      cyc();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
